// File: rtl/reg_latency_pkg.sv
// Shared register map for the GTF raw latency register file: channel offsets,
// global page addresses, CONTROL bit positions and the ID constant.
package reg_latency_pkg;

  localparam logic [7:0] OFF_STATUS        = 8'h00;
  localparam logic [7:0] OFF_CONTROL       = 8'h04;
  localparam logic [7:0] OFF_ERR_INJ_COUNT = 8'h10;
  localparam logic [7:0] OFF_ERR_INJ_DELAY = 8'h14;
  localparam logic [7:0] OFF_ERR_INJ_REM   = 8'h18;
  localparam logic [7:0] OFF_LAT_PKT_CNT   = 8'h20;
  localparam logic [7:0] OFF_LAT_PENDING   = 8'h24;
  localparam logic [7:0] OFF_LAT_TX_TIME   = 8'h28;
  localparam logic [7:0] OFF_LAT_RX_TIME   = 8'h2C;
  localparam logic [7:0] OFF_ACC_LO        = 8'h30;
  localparam logic [7:0] OFF_ACC_HI        = 8'h34;
  localparam logic [7:0] OFF_DELTA_MAX     = 8'h38;
  localparam logic [7:0] OFF_DELTA_MIN     = 8'h3C;
  localparam logic [7:0] OFF_DELTA_ADJ     = 8'h40;
  localparam logic [7:0] OFF_DELTA_IDX     = 8'h44;

  localparam int CTRL_GTWIZ_RESET_ALL = 0;
  localparam int CTRL_TXDP_RESET      = 1;
  localparam int CTRL_RXDP_RESET      = 2;
  localparam int CTRL_LAT_ENABLE      = 4;
  localparam int CTRL_LAT_POP         = 5;
  localparam int CTRL_LAT_CLEAR       = 6;
  localparam int CTRL_ERR_INJ_START   = 8;
  localparam int STATUS_LINK_DOWN     = 2;

  localparam logic [31:0] ADDR_ID      = 32'h0000_0F00;
  localparam logic [31:0] ADDR_SCRATCH = 32'h0000_0F04;
  localparam logic [15:0] ID_UPPER     = 16'h4C41;
  localparam logic [31:0] CH_STRIDE    = 32'h0000_0100;

  function automatic logic [31:0] ch_addr(input int unsigned ch, input logic [7:0] off);
    return 32'(ch) * CH_STRIDE + {24'h0, off};
  endfunction

endpackage

// File: rtl/reg_latency_ch.sv
// One latency/error-injection channel: RW settings, command pulses, sticky
// link-down latch, accumulator high-word shadow and the per-channel read mux.
module reg_latency_ch
  import reg_latency_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int ACC_W = 48
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             wen,
  input  logic             ren,
  input  logic [7:0]       off,
  input  logic [31:0]      wdata,
  input  logic             link_status,
  input  logic             link_stable,
  input  logic [CNT_W-1:0] err_inj_remain,
  input  logic [CNT_W-1:0] lat_pending,
  input  logic [CNT_W-1:0] lat_tx_time,
  input  logic [CNT_W-1:0] lat_rx_time,
  input  logic [CNT_W-1:0] delta_max,
  input  logic [CNT_W-1:0] delta_min,
  input  logic [CNT_W-1:0] delta_adj,
  input  logic [ACC_W-1:0] delta_acc,
  input  logic [31:0]      delta_idx,
  output logic             gtwiz_reset_all,
  output logic             txdp_reset,
  output logic             rxdp_reset,
  output logic             lat_enable,
  output logic             lat_pop,
  output logic             lat_clear,
  output logic             err_inj_start,
  output logic [CNT_W-1:0] err_inj_count,
  output logic [CNT_W-1:0] err_inj_delay,
  output logic [CNT_W-1:0] lat_pkt_cnt,
  output logic [31:0]      rd_data
);

  logic             wr_status, wr_control;
  logic             link_d, link_fell, link_down;
  logic [ACC_W-33:0] acc_shadow;
  logic             unused_wdata;

  assign wr_status    = wen && (off == OFF_STATUS);
  assign wr_control   = wen && (off == OFF_CONTROL);
  assign link_fell    = link_d && !link_status;
  assign unused_wdata = ^{wdata[31:9], wdata[7], wdata[3]};

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      gtwiz_reset_all <= 1'b0;
      txdp_reset      <= 1'b0;
      rxdp_reset      <= 1'b0;
      lat_enable      <= 1'b0;
      lat_pop         <= 1'b0;
      lat_clear       <= 1'b0;
      err_inj_start   <= 1'b0;
    end else begin
      if (wr_control) begin
        gtwiz_reset_all <= wdata[CTRL_GTWIZ_RESET_ALL];
        txdp_reset      <= wdata[CTRL_TXDP_RESET];
        rxdp_reset      <= wdata[CTRL_RXDP_RESET];
        lat_enable      <= wdata[CTRL_LAT_ENABLE];
      end
      lat_pop       <= wr_control && wdata[CTRL_LAT_POP];
      lat_clear     <= wr_control && wdata[CTRL_LAT_CLEAR];
      err_inj_start <= wr_control && wdata[CTRL_ERR_INJ_START];
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      err_inj_count <= '0;
      err_inj_delay <= '0;
      lat_pkt_cnt   <= '0;
    end else if (wen) begin
      if (off == OFF_ERR_INJ_COUNT) err_inj_count <= wdata[CNT_W-1:0];
      if (off == OFF_ERR_INJ_DELAY) err_inj_delay <= wdata[CNT_W-1:0];
      if (off == OFF_LAT_PKT_CNT)   lat_pkt_cnt   <= wdata[CNT_W-1:0];
    end
  end

  // A new falling edge outranks a simultaneous W1C so a drop is never lost.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      link_d     <= 1'b0;
      link_down  <= 1'b0;
      acc_shadow <= '0;
    end else begin
      link_d <= link_status;
      if (link_fell)
        link_down <= 1'b1;
      else if (wr_status && wdata[STATUS_LINK_DOWN])
        link_down <= 1'b0;
      if (ren && (off == OFF_ACC_LO))
        acc_shadow <= delta_acc[ACC_W-1:32];
    end
  end

  always_comb begin
    rd_data = '0;
    case (off)
      OFF_STATUS:        rd_data = {29'h0, link_down, link_stable, link_status};
      OFF_CONTROL:       rd_data = {27'h0, lat_enable, 1'b0, rxdp_reset, txdp_reset, gtwiz_reset_all};
      OFF_ERR_INJ_COUNT: rd_data = 32'(err_inj_count);
      OFF_ERR_INJ_DELAY: rd_data = 32'(err_inj_delay);
      OFF_ERR_INJ_REM:   rd_data = 32'(err_inj_remain);
      OFF_LAT_PKT_CNT:   rd_data = 32'(lat_pkt_cnt);
      OFF_LAT_PENDING:   rd_data = 32'(lat_pending);
      OFF_LAT_TX_TIME:   rd_data = 32'(lat_tx_time);
      OFF_LAT_RX_TIME:   rd_data = 32'(lat_rx_time);
      OFF_ACC_LO:        rd_data = delta_acc[31:0];
      OFF_ACC_HI:        rd_data = 32'(acc_shadow);
      OFF_DELTA_MAX:     rd_data = 32'(delta_max);
      OFF_DELTA_MIN:     rd_data = 32'(delta_min);
      OFF_DELTA_ADJ:     rd_data = 32'(delta_adj);
      OFF_DELTA_IDX:     rd_data = delta_idx;
      default:           rd_data = '0;
    endcase
  end

endmodule

// File: rtl/reg_latency_raw_multi.sv
// Multi-channel register file top: address decode, global ID/scratch page
// and the registered, valid-qualified read path.
module reg_latency_raw_multi
  import reg_latency_pkg::*;
#(
  parameter int         NUM_CH  = 4,
  parameter int         CNT_W   = 16,
  parameter int         ACC_W   = 48,
  parameter logic [7:0] VERSION = 8'h02
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    wen,
  input  logic                    ren,
  input  logic [31:0]             addr,
  input  logic [31:0]             wdata,
  output logic [31:0]             rdata,
  output logic                    rvalid,
  output logic [NUM_CH-1:0]       IO_CONTROL_GTWIZ_RESET_ALL,
  output logic [NUM_CH-1:0]       IO_CONTROL_GTF_CH_TXDP_RESET,
  output logic [NUM_CH-1:0]       IO_CONTROL_GTF_CH_RXDP_RESET,
  output logic [NUM_CH-1:0]       IO_CONTROL_LAT_ENABLE,
  output logic [NUM_CH-1:0]       IO_CONTROL_LAT_POP,
  output logic [NUM_CH-1:0]       IO_CONTROL_LAT_CLEAR,
  output logic [NUM_CH-1:0]       IO_CONTROL_ERR_INJ_START,
  output logic [NUM_CH*CNT_W-1:0] IO_ERR_INJ_COUNT_VALUE,
  output logic [NUM_CH*CNT_W-1:0] IO_ERR_INJ_DELAY_VALUE,
  output logic [NUM_CH*CNT_W-1:0] IO_LAT_PKT_CNT_VALUE,
  input  logic [NUM_CH-1:0]       IO_STATUS_LINK_STATUS,
  input  logic [NUM_CH-1:0]       IO_STATUS_LINK_STABLE,
  input  logic [NUM_CH*CNT_W-1:0] IO_ERR_INJ_REMAIN_VALUE,
  input  logic [NUM_CH*CNT_W-1:0] IO_LAT_PENDING_VALUE,
  input  logic [NUM_CH*CNT_W-1:0] IO_LAT_TX_TIME_VALUE,
  input  logic [NUM_CH*CNT_W-1:0] IO_LAT_RX_TIME_VALUE,
  input  logic [NUM_CH*CNT_W-1:0] IO_LAT_DELTA_MAX_VALUE,
  input  logic [NUM_CH*CNT_W-1:0] IO_LAT_DELTA_MIN_VALUE,
  input  logic [NUM_CH*CNT_W-1:0] IO_LAT_DELTA_ADJ_VALUE,
  input  logic [NUM_CH*ACC_W-1:0] IO_LAT_DELTA_ACC_VALUE,
  input  logic [NUM_CH*32-1:0]    IO_LAT_DELTA_IDX_VALUE
);

  logic [3:0]  ch_sel;
  logic [7:0]  off;
  logic        ch_hit;
  logic [31:0] ch_rd [NUM_CH];
  logic [31:0] scratch;
  logic [31:0] rd_next;

  assign ch_sel = addr[11:8];
  assign off    = addr[7:0];
  assign ch_hit = (addr[31:12] == 20'h0) && ({1'b0, ch_sel} < 5'(NUM_CH));

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic sel;
    assign sel = ch_hit && (ch_sel == 4'(c));

    reg_latency_ch #(.CNT_W(CNT_W), .ACC_W(ACC_W)) u_ch (
      .aclk            (aclk),
      .areset          (areset),
      .wen             (wen && sel),
      .ren             (ren && sel),
      .off             (off),
      .wdata           (wdata),
      .link_status     (IO_STATUS_LINK_STATUS[c]),
      .link_stable     (IO_STATUS_LINK_STABLE[c]),
      .err_inj_remain  (IO_ERR_INJ_REMAIN_VALUE[c*CNT_W +: CNT_W]),
      .lat_pending     (IO_LAT_PENDING_VALUE[c*CNT_W +: CNT_W]),
      .lat_tx_time     (IO_LAT_TX_TIME_VALUE[c*CNT_W +: CNT_W]),
      .lat_rx_time     (IO_LAT_RX_TIME_VALUE[c*CNT_W +: CNT_W]),
      .delta_max       (IO_LAT_DELTA_MAX_VALUE[c*CNT_W +: CNT_W]),
      .delta_min       (IO_LAT_DELTA_MIN_VALUE[c*CNT_W +: CNT_W]),
      .delta_adj       (IO_LAT_DELTA_ADJ_VALUE[c*CNT_W +: CNT_W]),
      .delta_acc       (IO_LAT_DELTA_ACC_VALUE[c*ACC_W +: ACC_W]),
      .delta_idx       (IO_LAT_DELTA_IDX_VALUE[c*32 +: 32]),
      .gtwiz_reset_all (IO_CONTROL_GTWIZ_RESET_ALL[c]),
      .txdp_reset      (IO_CONTROL_GTF_CH_TXDP_RESET[c]),
      .rxdp_reset      (IO_CONTROL_GTF_CH_RXDP_RESET[c]),
      .lat_enable      (IO_CONTROL_LAT_ENABLE[c]),
      .lat_pop         (IO_CONTROL_LAT_POP[c]),
      .lat_clear       (IO_CONTROL_LAT_CLEAR[c]),
      .err_inj_start   (IO_CONTROL_ERR_INJ_START[c]),
      .err_inj_count   (IO_ERR_INJ_COUNT_VALUE[c*CNT_W +: CNT_W]),
      .err_inj_delay   (IO_ERR_INJ_DELAY_VALUE[c*CNT_W +: CNT_W]),
      .lat_pkt_cnt     (IO_LAT_PKT_CNT_VALUE[c*CNT_W +: CNT_W]),
      .rd_data         (ch_rd[c])
    );
  end

  always_comb begin
    rd_next = '0;
    if (addr == ADDR_ID)
      rd_next = {ID_UPPER, VERSION, 8'(NUM_CH)};
    else if (addr == ADDR_SCRATCH)
      rd_next = scratch;
    else if (ch_hit)
      for (int c = 0; c < NUM_CH; c++)
        if (ch_sel == 4'(c)) rd_next = ch_rd[c];
  end

  // Read data is captured from pre-write state, so a same-edge write is not visible yet.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      scratch <= '0;
      rdata   <= '0;
      rvalid  <= 1'b0;
    end else begin
      if (wen && (addr == ADDR_SCRATCH)) scratch <= wdata;
      rvalid <= ren;
      rdata  <= ren ? rd_next : 32'h0;
    end
  end

endmodule

// File: tb/tb_reg_latency_raw_multi.sv
// Directed scoreboard bench for reg_latency_raw_multi: reads push expected data,
// a negedge monitor pops and compares whenever a read response is due.
module tb_reg_latency_raw_multi;
  import reg_latency_pkg::*;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;
  localparam int ACC_W  = 48;

  logic        aclk = 1'b0, areset = 1'b1, wen = 1'b0, ren = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        rvalid;
  logic [NUM_CH-1:0] gtwiz, txdp, rxdp, lat_en, pop, clr, inj_start;
  logic [NUM_CH*CNT_W-1:0] inj_count, inj_delay, pkt_cnt;
  logic [NUM_CH-1:0] link_status = '0, link_stable = '0;
  logic [NUM_CH*CNT_W-1:0] remain = '0, pending = '0, tx_time = '0, rx_time = '0;
  logic [NUM_CH*CNT_W-1:0] dmax = '0, dmin = '0, dadj = '0;
  logic [NUM_CH*ACC_W-1:0] acc = '0;
  logic [NUM_CH*32-1:0]    idx = '0;

  reg_latency_raw_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .ACC_W(ACC_W), .VERSION(8'h02)) dut (
    .aclk(aclk), .areset(areset), .wen(wen), .ren(ren), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rvalid(rvalid),
    .IO_CONTROL_GTWIZ_RESET_ALL(gtwiz), .IO_CONTROL_GTF_CH_TXDP_RESET(txdp),
    .IO_CONTROL_GTF_CH_RXDP_RESET(rxdp), .IO_CONTROL_LAT_ENABLE(lat_en),
    .IO_CONTROL_LAT_POP(pop), .IO_CONTROL_LAT_CLEAR(clr), .IO_CONTROL_ERR_INJ_START(inj_start),
    .IO_ERR_INJ_COUNT_VALUE(inj_count), .IO_ERR_INJ_DELAY_VALUE(inj_delay),
    .IO_LAT_PKT_CNT_VALUE(pkt_cnt),
    .IO_STATUS_LINK_STATUS(link_status), .IO_STATUS_LINK_STABLE(link_stable),
    .IO_ERR_INJ_REMAIN_VALUE(remain), .IO_LAT_PENDING_VALUE(pending),
    .IO_LAT_TX_TIME_VALUE(tx_time), .IO_LAT_RX_TIME_VALUE(rx_time),
    .IO_LAT_DELTA_MAX_VALUE(dmax), .IO_LAT_DELTA_MIN_VALUE(dmin),
    .IO_LAT_DELTA_ADJ_VALUE(dadj), .IO_LAT_DELTA_ACC_VALUE(acc),
    .IO_LAT_DELTA_IDX_VALUE(idx)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];
  int          due_q[$];
  string       name_q[$];

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // A response is due exactly one cycle after its ren edge; any other cycle must be idle.
  always @(negedge aclk) begin
    if (!areset) begin
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        checkOutput({name_q[0], "_rvalid"}, 64'(rvalid), 64'd1);
        checkOutput(name_q[0], 64'(rdata), 64'(exp_q[0]));
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
        void'(name_q.pop_front());
      end else begin
        checkOutput("idle_read_port", {31'h0, rvalid, rdata}, 64'd0);
      end
    end
  end

  task automatic applyStimulus(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    wen = w; ren = r; addr = a; wdata = d;
    @(posedge aclk);
    #1;
    wen = 1'b0; ren = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    applyStimulus(1'b1, 1'b0, a, d);
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string name);
    exp_q.push_back(exp); due_q.push_back(cyc + 1); name_q.push_back(name);
    applyStimulus(1'b0, 1'b1, a, 32'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && due_q.size() > 0; i++) idle(1);
    if (due_q.size() > 0) begin
      checkOutput("drain_timeout", 64'(due_q.size()), 64'd0);
      exp_q.delete(); due_q.delete(); name_q.delete();
    end
  endtask

  function automatic logic any_output();
    return |{gtwiz, txdp, rxdp, lat_en, pop, clr, inj_start, inj_count, inj_delay, pkt_cnt, rdata, rvalid};
  endfunction

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge aclk);
    #1;
    checkOutput("reset_outputs", 64'(any_output()), 64'd0);
    areset = 1'b0;
    idle(1);

    // Global page
    bus_read(ADDR_ID, 32'h4C41_0204, "id");
    bus_write(ADDR_SCRATCH, 32'hA5A5_5A5A);
    bus_read(ADDR_SCRATCH, 32'hA5A5_5A5A, "scratch");
    drain();

    // CONTROL levels and pulses on ch2
    bus_write(ch_addr(2, OFF_CONTROL), 32'h170);
    checkOutput("ch2_pulse_pop",   64'(pop),       64'h4);
    checkOutput("ch2_pulse_clear", 64'(clr),       64'h4);
    checkOutput("ch2_pulse_inj",   64'(inj_start), 64'h4);
    checkOutput("ch2_lat_enable",  64'(lat_en),    64'h4);
    checkOutput("ch2_other_lvls",  64'({gtwiz, txdp, rxdp}), 64'h0);
    idle(1);
    checkOutput("ch2_pulses_low",  64'({pop, clr, inj_start}), 64'h0);
    checkOutput("ch2_lat_enable_hold", 64'(lat_en), 64'h4);
    bus_read(ch_addr(2, OFF_CONTROL), 32'h10, "ch2_control_rb");
    drain();

    // Back-to-back POP writes on ch0
    bus_write(ch_addr(0, OFF_CONTROL), 32'h27);
    checkOutput("b2b_pop_1", 64'(pop), 64'h1);
    bus_write(ch_addr(0, OFF_CONTROL), 32'h27);
    checkOutput("b2b_pop_2", 64'(pop), 64'h1);
    checkOutput("ch0_levels", 64'({gtwiz[0], txdp[0], rxdp[0]}), 64'h7);
    idle(1);
    checkOutput("b2b_pop_end", 64'(pop), 64'h0);
    bus_read(ch_addr(0, OFF_CONTROL), 32'h7, "ch0_control_rb");
    drain();

    // Sticky link-down on ch1
    link_status[1] = 1'b1; link_stable[1] = 1'b1;
    idle(1);
    link_status[1] = 1'b0;
    idle(1);
    bus_read(ch_addr(1, OFF_STATUS), 32'h6, "ch1_link_down_set");
    bus_write(ch_addr(1, OFF_STATUS), 32'h4);
    bus_read(ch_addr(1, OFF_STATUS), 32'h2, "ch1_link_down_clr");
    link_status[1] = 1'b1;
    idle(1);
    link_status[1] = 1'b0;
    bus_write(ch_addr(1, OFF_STATUS), 32'h4);
    bus_read(ch_addr(1, OFF_STATUS), 32'h6, "ch1_set_beats_clr");
    exp_q.push_back(32'h6); due_q.push_back(cyc + 1); name_q.push_back("ch1_rd_before_wr");
    applyStimulus(1'b1, 1'b1, ch_addr(1, OFF_STATUS), 32'h4);
    bus_read(ch_addr(1, OFF_STATUS), 32'h2, "ch1_after_same_cycle_wr");
    drain();

    // Accumulator snapshot on ch3
    acc[3*ACC_W +: ACC_W] = 48'h1234_89AB_CDEF;
    bus_read(ch_addr(3, OFF_ACC_LO), 32'h89AB_CDEF, "ch3_acc_lo");
    acc[3*ACC_W +: ACC_W] = 48'h5555_0000_0000;
    bus_read(ch_addr(3, OFF_ACC_HI), 32'h0000_1234, "ch3_acc_hi_shadow");
    bus_read(ch_addr(3, OFF_ACC_LO), 32'h0, "ch3_acc_lo_2");
    bus_read(ch_addr(3, OFF_ACC_HI), 32'h0000_5555, "ch3_acc_hi_2");

    // RO fields
    tx_time[1*CNT_W +: CNT_W] = 16'hBEEF;
    idx[0 +: 32] = 32'hCAFE_F00D;
    dmin[2*CNT_W +: CNT_W] = 16'h8001;
    bus_read(ch_addr(1, OFF_LAT_TX_TIME), 32'h0000_BEEF, "ch1_tx_time");
    bus_read(ch_addr(0, OFF_DELTA_IDX), 32'hCAFE_F00D, "ch0_delta_idx");
    bus_read(ch_addr(2, OFF_DELTA_MIN), 32'h0000_8001, "ch2_delta_min");
    drain();

    // Decode boundaries
    bus_write(ch_addr(0, OFF_ERR_INJ_COUNT), 32'hFFFF_0020);
    bus_write(32'h0000_0500, 32'h33);
    bus_write(32'h0000_1000, 32'h44);
    bus_write(32'h0000_1010, 32'h55);
    checkOutput("count_bus", 64'(inj_count), 64'h20);
    bus_read(ch_addr(0, OFF_ERR_INJ_COUNT), 32'h20, "ch0_count_rb");
    bus_read(32'h0000_0500, 32'h0, "ch5_read_zero");
    bus_read(32'h0000_1000, 32'h0, "addr_1000_zero");
    bus_read(32'h0000_1010, 32'h0, "addr_1010_zero");
    bus_read(ch_addr(0, 8'h08), 32'h0, "ch0_hole_zero");
    drain();

    // Reset while a read response is in flight
    bus_write(ADDR_SCRATCH, 32'h1234_5678);
    applyStimulus(1'b0, 1'b1, ADDR_SCRATCH, 32'h0);
    areset = 1'b1;
    #1;
    checkOutput("rvalid_async_clr", 64'(rvalid), 64'd0);
    checkOutput("outputs_async_clr", 64'(any_output()), 64'd0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    idle(2);
    bus_read(ADDR_SCRATCH, 32'h0, "scratch_after_reset");
    bus_read(ch_addr(1, OFF_STATUS), 32'h2, "ch1_latch_after_reset");
    drain();
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_latency_raw_multi.md
# reg_latency_raw_multi

Parametrised, multi-channel control/status register file for the GTF raw latency test design. It sits between the AXI-Lite-to-register bridge (`wen`/`ren`/`addr`/`wdata`/`rdata`) and NUM_CH independent latency/error-injection channels. It adds several features:
- a register read strobe with a registered, valid-qualified read path;
- W1C sticky link-down latches per channel;
- self-clearing command pulses;
- atomic snapshot reads of wide latency accumulators;
- a global ID/scratch page.

## Interface
- NUM_CH, 4: channel count, 1..15.
- CNT_W, 16: width of count/delay/time/min/max/adj fields, 1..32.
- ACC_W, 48: delta accumulator width, 33..64.
- VERSION, 8'h02: returned in the ID register.
- aclk  in  1  register clock; all logic on rising edge.
- areset  in  1  asynchronous, active-high reset.
- wen  in  1  write strobe, one cycle per access.
- ren  in  1  read strobe, one cycle per access.
- addr  in  32  byte address.
- wdata  in  32  write data.
- rdata  out  32  read data, valid when rvalid.
- rvalid  out  1  one-cycle read-data qualifier.
- IO_CONTROL_GTWIZ_RESET_ALL, IO_CONTROL_GTF_CH_TXDP_RESET, IO_CONTROL_GTF_CH_RXDP_RESET, IO_CONTROL_LAT_ENABLE  out  NUM_CH each  per-channel level controls.
- IO_CONTROL_LAT_POP, IO_CONTROL_LAT_CLEAR, IO_CONTROL_ERR_INJ_START  out  NUM_CH each  per-channel one-cycle pulses.
- IO_ERR_INJ_COUNT_VALUE, IO_ERR_INJ_DELAY_VALUE, IO_LAT_PKT_CNT_VALUE  out  NUM_CH*CNT_W each  RW settings; channel c occupies bits [c*CNT_W +: CNT_W].
- IO_STATUS_LINK_STATUS, IO_STATUS_LINK_STABLE  in  NUM_CH each  live link state, already synchronous to aclk.
- IO_ERR_INJ_REMAIN_VALUE, IO_LAT_PENDING_VALUE, IO_LAT_TX_TIME_VALUE, IO_LAT_RX_TIME_VALUE, IO_LAT_DELTA_MAX_VALUE, IO_LAT_DELTA_MIN_VALUE, IO_LAT_DELTA_ADJ_VALUE  in  NUM_CH*CNT_W each  RO status.
- IO_LAT_DELTA_ACC_VALUE  in  NUM_CH*ACC_W  delta accumulators.
- IO_LAT_DELTA_IDX_VALUE  in  NUM_CH*32  sample index.

## Operation

**Address decode**
- A channel access requires addr[31:12]==0 and ch=addr[11:8] < NUM_CH; off=addr[7:0].
- The global page is addr=0xF00/0xF04.
- Every other address reads 0, and writes to it are ignored.

**Channel offsets**
- 0x00 STATUS:
  - bit0 link_status (live).
  - bit1 link_stable (live).
  - bit2 link_down_latched: sticky. Set the cycle after IO_STATUS_LINK_STATUS[ch] goes 1->0. Cleared by a write with wdata[2]=1 to STATUS. Set wins over a simultaneous clear.
- 0x04 CONTROL:
  - bits 0,1,2,4 are RW levels.
  - bits 5 (POP), 6 (CLEAR), 8 (ERR_INJ_START) are pulses and always read 0.
- 0x10 ERR_INJ_COUNT RW; 0x14 ERR_INJ_DELAY RW; 0x18 ERR_INJ_REMAIN RO; 0x20 LAT_PKT_CNT RW. RW fields use wdata[CNT_W-1:0]; all four zero-extended on read.
- 0x24 PENDING, 0x28 TX_TIME, 0x2C RX_TIME, 0x3C DELTA_MIN, 0x40 DELTA_ADJ: RO, zero-extended.
- 0x30 ACC_LO: returns acc[31:0]. The same read captures acc[ACC_W-1:32] into a per-channel shadow register.
- 0x34 ACC_HI: returns the shadow, zero-extended. Shadow holds until the next ACC_LO read of that channel.
- 0x38 DELTA_MAX RO; 0x44 DELTA_IDX RO 32 bits.

**Global page**
- 0xF00 ID RO = {16'h4C41, VERSION, NUM_CH[7:0]}.
- 0xF04 SCRATCH RW 32 bits.

**Pulses**
- A CONTROL write with bit5/6/8 set drives the matching channel's pulse output high for exactly one cycle, then low.
- Back-to-back writes give back-to-back pulses.

## Timing
- Writes: register outputs update at the aclk edge sampling wen; visible on outputs the next cycle.
- Reads: rdata/rvalid registered, 1-cycle latency. With ren at edge N, rvalid=1 and rdata=value during cycle N+1. rvalid=0 and rdata=0 when there is no read.
- Read data reflects state before the same-edge write (wen and ren in the same cycle, same address).
- The shadow capture on an ACC_LO read occurs at the same edge as the read-data register.
- Reset values: every output register is 0, including rdata, rvalid, all pulses, sticky latches, shadows, SCRATCH, and the link_status delay flop.
- areset asserted mid-read forces rvalid=0 immediately; a pending read is dropped and is not replayed.
- A link_status falling edge present at reset release is not latched, because the delay flop resets to 0.

## Structure
- Package reg_latency_pkg holds the channel offset constants, the global addresses, the ID upper constant 16'h4C41, and the channel stride 0x100.
- Sub-module reg_latency_ch is instantiated NUM_CH times by generate. It holds one channel's RW/pulse/sticky/shadow state and its combinational offset-to-read-data mux.
- The top level holds channel select, global page, and the registered rdata/rvalid.

## Test plan
- Reset, then read 0xF00 with NUM_CH=4, VERSION=2 -> rdata=0x4C410204, rvalid high one cycle after ren, 0 otherwise.
- Write 0x204=0x170 -> ch2 LAT_ENABLE=1 stays high; POP, CLEAR, ERR_INJ_START ch2 each high exactly one cycle; other channels untouched; readback of 0x204=0x010.
- Drive ch1 link_status 1->0 -> 0x100 bit2=1. Write 0x100=0x4 -> bit2=0. Repeat with the clear write in the same cycle as a new falling edge -> bit2 stays 1.
- ch3 acc=0x1234_89ABCDEF: read 0x330 -> 0x89ABCDEF; change acc to 0x5555_00000000; read 0x334 -> 0x00001234.
- Write 0x20 to ch0 0x010, and to 0x500 (ch5 ≥ NUM_CH) and 0x1000 -> ch0 count=0x20; other writes ignored; reads of 0x500/0x1000 return 0.
- Assert areset the cycle after ren -> rvalid and all outputs 0 immediately; SCRATCH reads 0 after release.
